// File: rtl/xb_io_fifo_slv.sv
// ---------------------------------------------------------------------------
// xb_io_fifo_slv
//
// Extended-I/O responder that lets AVR core firmware push bytes into a small
// FIFO through three memory-mapped registers, while fabric logic drains the
// FIFO over a valid/ready byte stream.
//
// Register map (low address byte, decoded only when core_dm_sel is low):
//   CTRL_ADDR  R/W  [0] EN, [1] FLUSH (write-1 pulse, reads 0), [2] IE
//   STAT_ADDR  R    [0] EMPTY, [1] FULL, [2] OVF (sticky, write 1 to clear)
//   DATA_ADDR  W pushes a byte; R returns the occupancy count
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   core_ramadr_lo8     core data-space address, low byte
//   core_dm_sel         high = access targets data memory, not this block
//   core_ramre/ramwe    core read / write strobes
//   core_dbusout        core write data
//   xb_io_dbusout       read data toward the core read mux (0 when idle)
//   xb_io_out_en        read mux select, high on a decoded read
//   strm_valid/data     FIFO head toward the fabric consumer
//   strm_ready          fabric consumer accepts the head byte
//   xb_irq              registered level interrupt
// ---------------------------------------------------------------------------
module xb_io_fifo_slv #(
  parameter logic [7:0] CTRL_ADDR = 8'hE0,
  parameter logic [7:0] STAT_ADDR = 8'hE1,
  parameter logic [7:0] DATA_ADDR = 8'hE2,
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] core_ramadr_lo8,
  input  logic       core_dm_sel,
  input  logic       core_ramre,
  input  logic       core_ramwe,
  input  logic [7:0] core_dbusout,
  output logic [7:0] xb_io_dbusout,
  output logic       xb_io_out_en,
  output logic       strm_valid,
  output logic [7:0] strm_data,
  input  logic       strm_ready,
  output logic       xb_irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Control/status state
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Storage is never reset; only the pointers and count define contents.
  logic [7:0]    mem_q [DEPTH];

  // Address decode
  logic hit_ctrl, hit_stat, hit_data;
  logic wr_ctrl, wr_stat, wr_data;
  logic empty, full;
  logic flush, push_req, pop, push;
  logic [7:0] rd_mux;

  // Bits 7:3 of the write bus carry no register state.
  logic unused_wdata;
  assign unused_wdata = ^core_dbusout[7:3];

  assign hit_ctrl = !core_dm_sel && (core_ramadr_lo8 == CTRL_ADDR);
  assign hit_stat = !core_dm_sel && (core_ramadr_lo8 == STAT_ADDR);
  assign hit_data = !core_dm_sel && (core_ramadr_lo8 == DATA_ADDR);

  assign wr_ctrl = core_ramwe && hit_ctrl;
  assign wr_stat = core_ramwe && hit_stat;
  assign wr_data = core_ramwe && hit_data;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  assign strm_valid = en_q && !empty;
  assign strm_data  = mem_q[rd_ptr_q];

  assign flush    = wr_ctrl && core_dbusout[1];
  assign pop      = strm_valid && strm_ready;
  assign push_req = wr_data && en_q;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push     = push_req && (!full || pop);

  // Zero-latency read mux
  always_comb begin
    rd_mux = 8'h00;
    if (hit_ctrl)      rd_mux = {5'b0, ie_q, 1'b0, en_q};
    else if (hit_stat) rd_mux = {5'b0, ovf_q, full, empty};
    else if (hit_data) rd_mux = 8'(cnt_q);
  end

  assign xb_io_out_en  = core_ramre && (hit_ctrl || hit_stat || hit_data);
  assign xb_io_dbusout = xb_io_out_en ? rd_mux : 8'h00;

  // Next-state logic
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (wr_ctrl) begin
      en_d = core_dbusout[0];
      ie_d = core_dbusout[2];
    end

    if (wr_stat && core_dbusout[2]) ovf_d = 1'b0;
    // A fresh overflow outranks a clear landing in the same cycle.
    if (push_req && full && !pop)   ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Registered from the present flags, so irq trails them by one edge.
    irq_d = ie_q && en_q && (empty || ovf_q);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) mem_q[wr_ptr_q] <= core_dbusout;
  end

  assign xb_irq = irq_q;

endmodule

// File: tb/tb_xb_io_fifo_slv.sv
module tb_xb_io_fifo_slv;

  localparam logic [7:0] CTRL = 8'hE0;
  localparam logic [7:0] STAT = 8'hE1;
  localparam logic [7:0] DATA = 8'hE2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] core_ramadr_lo8;
  logic       core_dm_sel;
  logic       core_ramre;
  logic       core_ramwe;
  logic [7:0] core_dbusout;
  logic [7:0] xb_io_dbusout;
  logic       xb_io_out_en;
  logic       strm_valid;
  logic [7:0] strm_data;
  logic       strm_ready;
  logic       xb_irq;

  int n_chk  = 0;
  int n_fail = 0;

  xb_io_fifo_slv dut (
    .clk             (clk),
    .rst             (rst),
    .core_ramadr_lo8 (core_ramadr_lo8),
    .core_dm_sel     (core_dm_sel),
    .core_ramre      (core_ramre),
    .core_ramwe      (core_ramwe),
    .core_dbusout    (core_dbusout),
    .xb_io_dbusout   (xb_io_dbusout),
    .xb_io_out_en    (xb_io_out_en),
    .strm_valid      (strm_valid),
    .strm_data       (strm_data),
    .strm_ready      (strm_ready),
    .xb_irq          (xb_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write strobe spanning exactly one rising edge.
  task automatic cpu_write(input logic [7:0] adr, input logic [7:0] dat);
    @(negedge clk);
    core_ramadr_lo8 = adr;
    core_dbusout    = dat;
    core_ramwe      = 1'b1;
    @(negedge clk);
    core_ramwe      = 1'b0;
  endtask

  // Combinational read sampled mid-low-phase.
  task automatic cpu_read(input logic [7:0] adr, output logic [7:0] dat);
    @(negedge clk);
    core_ramadr_lo8 = adr;
    core_ramre      = 1'b1;
    #1;
    dat        = xb_io_dbusout;
    core_ramre = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    rst = 1'b1; core_ramadr_lo8 = 8'h00; core_dm_sel = 1'b0;
    core_ramre = 1'b0; core_ramwe = 1'b0; core_dbusout = 8'h00; strm_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    cpu_read(CTRL, rd); chk("rst_ctrl", rd, 8'h00);
    cpu_read(STAT, rd); chk("rst_stat", rd, 8'h01);
    cpu_read(DATA, rd); chk("rst_data", rd, 8'h00);
    chk("rst_irq", xb_irq, 1'b0);
    chk("rst_valid", strm_valid, 1'b0);
    // Decode gating: dm_sel access and unmapped address give no read data
    @(negedge clk);
    core_dm_sel = 1'b1; core_ramadr_lo8 = STAT; core_ramre = 1'b1; #1;
    chk("dmsel_oen", xb_io_out_en, 1'b0);
    chk("dmsel_bus", xb_io_dbusout, 8'h00);
    core_dm_sel = 1'b0; core_ramadr_lo8 = 8'hE3; #1;
    chk("unmapped_oen", xb_io_out_en, 1'b0);
    core_ramre = 1'b0;

    // 2: two bytes, back-to-back beats
    cpu_write(CTRL, 8'h01);
    cpu_write(DATA, 8'hA5);
    cpu_write(DATA, 8'h5A);
    cpu_read(DATA, rd); chk("t2_count", rd, 8'h02);
    @(negedge clk);
    strm_ready = 1'b1; #1;
    chk("t2_v0", strm_valid, 1'b1); chk("t2_d0", strm_data, 8'hA5);
    @(negedge clk); #1;
    chk("t2_v1", strm_valid, 1'b1); chk("t2_d1", strm_data, 8'h5A);
    @(negedge clk); #1;
    chk("t2_v2", strm_valid, 1'b0);
    strm_ready = 1'b0;
    cpu_read(STAT, rd); chk("t2_stat", rd, 8'h01);

    // 3: fill past full, overflow, clear OVF
    do_reset();
    cpu_write(CTRL, 8'h01);
    for (int i = 0; i < 17; i++) cpu_write(DATA, 8'h10 + 8'(i));
    cpu_read(STAT, rd); chk("t3_stat", rd, 8'h06);
    cpu_read(DATA, rd); chk("t3_count", rd, 8'h10);
    chk("t3_head", strm_data, 8'h10);
    cpu_write(STAT, 8'h04);
    cpu_read(STAT, rd); chk("t3_stat_clr", rd, 8'h02);

    // 4: push into full FIFO while popping
    @(negedge clk);
    core_ramadr_lo8 = DATA; core_dbusout = 8'hC3; core_ramwe = 1'b1; strm_ready = 1'b1;
    @(negedge clk);
    core_ramwe = 1'b0; strm_ready = 1'b0;
    cpu_read(DATA, rd); chk("t4_count", rd, 8'h10);
    cpu_read(STAT, rd); chk("t4_stat", rd, 8'h02);
    @(negedge clk);
    strm_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t4_v%0d", i), strm_valid, 1'b1);
      chk($sformatf("t4_d%0d", i), strm_data, (i == 15) ? 8'hC3 : 8'h11 + 8'(i));
      @(negedge clk);
    end
    #1;
    chk("t4_drained", strm_valid, 1'b0);
    strm_ready = 1'b0;
    cpu_read(STAT, rd); chk("t4_stat_end", rd, 8'h01);

    // 5: flush discards contents and a same-cycle pop
    for (int i = 0; i < 5; i++) cpu_write(DATA, 8'h40 + 8'(i));
    @(negedge clk);
    core_ramadr_lo8 = CTRL; core_dbusout = 8'h03; core_ramwe = 1'b1; strm_ready = 1'b1;
    @(negedge clk);
    core_ramwe = 1'b0; strm_ready = 1'b0; #1;
    chk("t5_valid", strm_valid, 1'b0);
    cpu_read(DATA, rd); chk("t5_count", rd, 8'h00);
    cpu_read(CTRL, rd); chk("t5_ctrl", rd, 8'h01);
    cpu_write(DATA, 8'h99);
    #1;
    chk("t5_new_head", strm_data, 8'h99);
    cpu_read(DATA, rd); chk("t5_count1", rd, 8'h01);

    // 6: interrupt timing and reset with data queued
    cpu_write(CTRL, 8'h07);          // flush + EN + IE -> empty
    #1; chk("t6_irq_lat", xb_irq, 1'b0);
    @(negedge clk); #1; chk("t6_irq_on", xb_irq, 1'b1);
    cpu_write(DATA, 8'h01);
    #1; chk("t6_irq_hold", xb_irq, 1'b1);
    @(negedge clk); #1; chk("t6_irq_off", xb_irq, 1'b0);
    for (int i = 0; i < 3; i++) cpu_write(DATA, 8'h02 + 8'(i));
    cpu_read(DATA, rd); chk("t6_count", rd, 8'h04);
    do_reset();
    cpu_read(STAT, rd); chk("t6_rst_stat", rd, 8'h01);
    cpu_read(CTRL, rd); chk("t6_rst_ctrl", rd, 8'h00);
    chk("t6_rst_irq", xb_irq, 1'b0);
    chk("t6_rst_valid", strm_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
